// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, reset PC and fetch FSM states.
package proc_pkg;
  localparam int AW = 7;
  localparam int IW = 8;
  localparam logic [AW-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, registers the
// combinational ROM data into the IR and offers it to decode.
// Optional macro FETCH_BRANCH_REL_EN: redirect target = ir_pc_o + signed offset.
//
// Handshake: ir_o/ir_pc_o are offered while ir_valid_o is high; the transfer
// happens on a rising edge where ir_valid_o && ir_ready_i. While valid and not
// ready the offered values never change. A redirect or halt withdraws the
// offer (flush) without a transfer, even if ir_ready_i is high.
module fetch_unit #(
  parameter int              AW       = proc_pkg::AW,
  parameter int              IW       = proc_pkg::IW,
  parameter logic [AW-1:0]   RESET_PC = proc_pkg::RESET_PC
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  output logic [AW-1:0] addr_o,
  input  logic [IW-1:0] instr_i,
  output logic [IW-1:0] ir_o,
  output logic [AW-1:0] ir_pc_o,
  output logic          ir_valid_o,
  input  logic          ir_ready_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_tgt_i,
  input  logic          halt_i,
  output logic          done_o,
  output logic [1:0]    dbg_state_o
);
  import proc_pkg::*;

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] tgt_addr;
  logic          advance;

  // Redirect target: relative offsets wrap naturally in the AW-bit add.
`ifdef FETCH_BRANCH_REL_EN
  assign tgt_addr = ir_pc_q + redirect_tgt_i;
`else
  assign tgt_addr = redirect_tgt_i;
`endif

  assign advance = (state_q == RUN) && (!valid_q || ir_ready_i);

  // Next-state and PC/IR update; halt beats redirect beats advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          valid_d = 1'b0;
        end
      end
      RUN: begin
        if (halt_i) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (redirect_i) begin
          pc_d    = tgt_addr;
          valid_d = 1'b0;
        end else if (advance) begin
          ir_d    = instr_i;
          ir_pc_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
    end
  end

  assign addr_o      = pc_q;
  assign ir_o        = ir_q;
  assign ir_pc_o     = ir_pc_q;
  assign ir_valid_o  = valid_q;
  assign done_o      = (state_q == HALT);
  assign dbg_state_o = state_q;
endmodule
